// File: rtl/kbd_fifo_ctrl.sv
// Keyboard receive FIFO with memory-mapped DATA and STATUS/CTRL registers.
// A level interrupt vector is raised while unread bytes remain queued.
`ifndef Key_base
`define Key_base 64'h0000_0000_0000_2000
`endif

// state     | meaning
// S_IDLE    | no request; waits for irq_en with data queued
// S_PENDING | vector driven until the CPU acknowledges
// S_ACKED   | acknowledged; re-arms after a DATA pop leaves data behind
module kbd_fifo_ctrl #(
    parameter int          DEPTH  = 8,
    parameter logic [63:0] BASE   = `Key_base,
    parameter logic [3:0]  VECTOR = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ascii,
    input  logic        key_pressed,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    input  logic [63:0] bus_write_data,
    output logic [63:0] bus_read_data,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_ack
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_ACKED} irq_state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_irq_en;
    logic          r_key_d1;
    logic          r_key_d2;
    logic          r_rd_d1;
    logic          r_rd_d2;
    logic          r_wr_d1;
    logic          r_wr_d2;
    logic          r_ack_d;
    logic [7:0]    r_ascii;
    logic [2:0]    r_wdata;
    irq_state_t    r_state;
    logic          r_repend;

    logic          w_rd_sel;
    logic          w_stat_sel;
    logic          w_wr_sel;
    logic          w_nonempty;
    logic          w_full;
    logic          w_rd_evt;
    logic          w_wr_evt;
    logic          w_flush;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;
    logic          w_irq_off;
    logic [CW-1:0] w_count_nxt;
    logic [63:0]   w_status;
    logic          w_unused;

    assign w_rd_sel   = bus_read_enable && (bus_address == BASE);
    assign w_stat_sel = (bus_address == BASE + 64'd8);
    assign w_wr_sel   = bus_write_enable && w_stat_sel;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_rd_evt   = r_rd_d1 & ~r_rd_d2;
    assign w_wr_evt   = r_wr_d1 & ~r_wr_d2;
    assign w_flush    = w_wr_evt & r_wdata[2];
    assign w_pop      = w_rd_evt & w_nonempty;
    assign w_push_req = r_key_d1 & ~r_key_d2 & (r_ascii != 8'd0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_push     = w_push_req & ~w_flush & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_flush & w_full & ~w_pop;
    assign w_irq_off  = ~r_irq_en | (w_wr_evt & ~r_wdata[0]);

    assign w_count_nxt = w_flush ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_status    = {48'd0, 8'(r_count), 4'd0, r_irq_en, r_ovf, w_full, w_nonempty};
    assign w_unused    = ^bus_write_data[63:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_d1 <= 1'b0;
            r_key_d2 <= 1'b0;
            r_rd_d1  <= 1'b0;
            r_rd_d2  <= 1'b0;
            r_wr_d1  <= 1'b0;
            r_wr_d2  <= 1'b0;
            r_ack_d  <= 1'b0;
            r_ascii  <= 8'd0;
            r_wdata  <= 3'd0;
        end else begin
            r_key_d1 <= key_pressed;
            r_key_d2 <= r_key_d1;
            r_rd_d1  <= w_rd_sel;
            r_rd_d2  <= r_rd_d1;
            r_wr_d1  <= w_wr_sel;
            r_wr_d2  <= r_wr_d1;
            r_ack_d  <= interrupt_ack;
            r_ascii  <= ascii;
            r_wdata  <= bus_write_data[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_ascii;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b1;
        end else begin
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            if (w_wr_evt) begin
                r_irq_en <= r_wdata[0];
                if (r_wdata[1]) r_ovf <= 1'b0;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_read_data <= '0;
        end else if (w_rd_evt) begin
            bus_read_data <= w_nonempty ? {56'd0, r_mem[r_rptr]} : 64'd0;
        end else if (bus_read_enable && w_stat_sel) begin
            bus_read_data <= w_status;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_repend         <= 1'b0;
            interrupt_vector <= 4'd0;
        end else if (w_irq_off || w_flush) begin
            r_state          <= S_IDLE;
            r_repend         <= 1'b0;
            interrupt_vector <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_nonempty) begin
                        r_state          <= S_PENDING;
                        interrupt_vector <= VECTOR;
                    end
                end
                S_PENDING: begin
                    if (r_ack_d) begin
                        r_state          <= S_ACKED;
                        interrupt_vector <= 4'd0;
                    end else if (w_count_nxt == '0) begin
                        r_state          <= S_IDLE;
                        interrupt_vector <= 4'd0;
                    end
                end
                S_ACKED: begin
                    // A pop seen while ack is still held is remembered until ack drops.
                    if (w_count_nxt == '0) begin
                        r_state  <= S_IDLE;
                        r_repend <= 1'b0;
                    end else if ((r_repend || w_pop) && !r_ack_d) begin
                        r_state          <= S_PENDING;
                        r_repend         <= 1'b0;
                        interrupt_vector <= VECTOR;
                    end else if (w_pop) begin
                        r_repend <= 1'b1;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_repend         <= 1'b0;
                    interrupt_vector <= 4'd0;
                end
            endcase
        end
    end
endmodule
